// File: rtl/kab_io_fabric_if.sv
// kab_io_fabric_if: processor-side IO bus between the core and the IO fabric
interface kab_io_fabric_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
);
  logic [ADDR_W-1:0] Sys_Address;
  logic [DATA_W-1:0] Sys_WrData;
  logic              Sys_WrEn;
  logic              Sys_RdEn;
  logic [DATA_W-1:0] Sys_RdData;
  logic              Sys_RdValid;
  modport master (output Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, input Sys_RdData, Sys_RdValid);
  modport slave  (input Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, output Sys_RdData, Sys_RdValid);
endinterface

// File: rtl/kab_io_fabric.sv
// kab_io_fabric: IO slot decoder with registered read-back and an integrated prioritised interrupt controller in slot 0
module kab_io_fabric #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int REG_AW = 4,
  parameter int NUM_SLOTS = 8,
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK = 8'hFE,
  parameter int NUM_IRQ = 8,
  localparam int SLOT_W = $clog2(NUM_SLOTS),
  localparam int IRQ_ID_W = $clog2(NUM_IRQ)
) (
  input  logic                          Sys_Clock,
  input  logic                          Sys_Reset,
  kab_io_fabric_if.slave                bus,
  output logic [NUM_SLOTS-1:0]          Slot_Sel,
  output logic [REG_AW-1:0]             Slot_RegAddr,
  output logic [DATA_W-1:0]             Slot_WrData,
  output logic                          Slot_WrEn,
  output logic                          Slot_RdEn,
  input  logic [NUM_SLOTS*DATA_W-1:0]   Slot_RdData,
  input  logic [NUM_IRQ-1:0]            Irq,
  output logic                          EIC_IntReq,
  output logic [IRQ_ID_W-1:0]           EIC_IntId,
  input  logic                          EIC_IntAck
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [SLOT_W-1:0] slot;
  logic [REG_AW-1:0] reg_a;
  logic pop, s0_wr, ack_hit, unused_addr;
  logic [NUM_IRQ-1:0] pending, mask, mode, irq_q, pend_nxt, mask_nxt, mode_nxt, cand, cand_nxt;
  logic [IRQ_ID_W-1:0] win;
  logic [DATA_W-1:0] s0_rd, rd_mux;
  assign slot = bus.Sys_Address[REG_AW +: SLOT_W];
  assign reg_a = bus.Sys_Address[REG_AW-1:0];
  assign unused_addr = ^bus.Sys_Address[ADDR_W-1:REG_AW+SLOT_W];
  assign pop = SLOT_MASK[slot] && slot != '0;
  assign Slot_Sel = ((bus.Sys_WrEn || bus.Sys_RdEn) && pop) ? NUM_SLOTS'(1) << slot : '0;
  assign Slot_RegAddr = reg_a;
  assign Slot_WrData = bus.Sys_WrData;
  assign Slot_WrEn = bus.Sys_WrEn && pop;
  assign Slot_RdEn = bus.Sys_RdEn && pop;
  assign s0_wr = bus.Sys_WrEn && slot == '0;
  assign ack_hit = state == REQ && EIC_IntAck;
  assign mask_nxt = (s0_wr && reg_a == REG_AW'(1)) ? bus.Sys_WrData[NUM_IRQ-1:0] : mask;
  assign mode_nxt = (s0_wr && reg_a == REG_AW'(2)) ? bus.Sys_WrData[NUM_IRQ-1:0] : mode;
  assign cand = pending & mask;
  assign cand_nxt = pend_nxt & mask_nxt;
  // edge channels: a fresh rising edge beats any simultaneous W1C or ack clear
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      pend_nxt[i] = mode[i] ? (Irq[i] && !irq_q[i]) || (pending[i] &&
        !((s0_wr && reg_a == REG_AW'(0) && bus.Sys_WrData[i]) || (ack_hit && EIC_IntId == IRQ_ID_W'(i)))) : Irq[i];
  end
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (cand[i]) win = IRQ_ID_W'(i);
  end
  assign s0_rd = reg_a == REG_AW'(0) ? DATA_W'(pending) :
                 reg_a == REG_AW'(1) ? DATA_W'(mask) :
                 reg_a == REG_AW'(2) ? DATA_W'(mode) :
                 reg_a == REG_AW'(3) ? {EIC_IntReq, (DATA_W-1)'(EIC_IntId)} : '0;
  assign rd_mux = slot == '0 ? s0_rd : pop ? Slot_RdData[int'(slot)*DATA_W +: DATA_W] : '0;
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state <= IDLE;
      EIC_IntReq <= 1'b0;
      EIC_IntId <= '0;
      pending <= '0;
      mask <= '0;
      mode <= '1;
      irq_q <= '0;
      bus.Sys_RdData <= '0;
      bus.Sys_RdValid <= 1'b0;
    end else begin
      irq_q <= Irq;
      pending <= pend_nxt;
      mask <= mask_nxt;
      mode <= mode_nxt;
      bus.Sys_RdValid <= bus.Sys_RdEn;
      if (bus.Sys_RdEn) bus.Sys_RdData <= rd_mux;
      if (state == IDLE) begin
        if (cand != '0) begin
          state <= REQ;
          EIC_IntReq <= 1'b1;
          EIC_IntId <= win;
        end
      end else if (ack_hit || !cand_nxt[EIC_IntId]) begin
        // withdraw follows the candidate bit in the same cycle it reads back as 0
        state <= IDLE;
        EIC_IntReq <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_kab_io_fabric.sv
// tb_kab_io_fabric: randomized and directed checks of kab_io_fabric against a behavioural model
module tb_kab_io_fabric;
  localparam logic [7:0] SM = 8'hFA;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  kab_io_fabric_if #(.DATA_W(32), .ADDR_W(30)) bus ();
  logic [7:0] sel;
  logic [3:0] raddr;
  logic [31:0] swd;
  logic swe, sre;
  logic [255:0] srd;
  logic [7:0] irq;
  logic req;
  logic [2:0] id;
  logic ack;
  kab_io_fabric #(.SLOT_MASK(SM)) dut (
    .Sys_Clock(clk), .Sys_Reset(rst), .bus(bus),
    .Slot_Sel(sel), .Slot_RegAddr(raddr), .Slot_WrData(swd), .Slot_WrEn(swe), .Slot_RdEn(sre),
    .Slot_RdData(srd), .Irq(irq), .EIC_IntReq(req), .EIC_IntId(id), .EIC_IntAck(ack)
  );
  int n_chk = 0;
  int n_pass = 0;
  bit live = 1'b0;
  logic [7:0] m_pend, m_mask, m_mode, m_prev, np, nm, nmd;
  logic m_req, m_rv, w1c;
  int m_id, ms, mr;
  logic [31:0] m_rdata;
  task automatic cmp(string nm_s, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm_s, act, exp, $time);
    else n_pass++;
  endtask
  function automatic int top(logic [7:0] v);
    int t = 0;
    for (int i = 0; i < 8; i++) if (v[i]) t = i;
    return t;
  endfunction
  function automatic logic [31:0] model_read(int s, int r);
    if (s != 0) return SM[s] ? srd[s*32 +: 32] : 32'h0;
    case (r)
      0: return 32'(m_pend);
      1: return 32'(m_mask);
      2: return 32'(m_mode);
      3: return {m_req, 28'h0, 3'(m_id)};
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    ms = int'(bus.Sys_Address[6:4]);
    mr = int'(bus.Sys_Address[3:0]);
    if (rst) begin
      m_pend = 0; m_mask = 0; m_mode = 8'hFF; m_prev = 0;
      m_req = 0; m_id = 0; m_rdata = 0; m_rv = 0;
    end else begin
      if (bus.Sys_RdEn) m_rdata = model_read(ms, mr);
      m_rv = bus.Sys_RdEn;
      nm = m_mask; nmd = m_mode; w1c = 0;
      if (bus.Sys_WrEn && ms == 0) begin
        if (mr == 0) w1c = 1;
        if (mr == 1) nm = bus.Sys_WrData[7:0];
        if (mr == 2) nmd = bus.Sys_WrData[7:0];
      end
      for (int i = 0; i < 8; i++)
        if (!m_mode[i]) np[i] = irq[i];
        else np[i] = (irq[i] && !m_prev[i]) ||
                     (m_pend[i] && !(w1c && bus.Sys_WrData[i]) && !(m_req && ack && m_id == i));
      if (!m_req) begin
        if ((m_pend & m_mask) != 0) begin m_req = 1; m_id = top(m_pend & m_mask); end
      end else if (ack || !(np[m_id] && nm[m_id])) m_req = 0;
      m_pend = np; m_mask = nm; m_mode = nmd; m_prev = irq;
    end
  end
  always @(negedge clk) if (live) begin
    int s;
    logic pop, acc;
    s = int'(bus.Sys_Address[6:4]);
    pop = SM[s] && s != 0;
    acc = bus.Sys_WrEn || bus.Sys_RdEn;
    cmp("slot_sel", 32'(sel), (acc && pop) ? 32'(1 << s) : 32'h0);
    cmp("slot_wren", 32'(swe), 32'(bus.Sys_WrEn && pop));
    cmp("slot_rden", 32'(sre), 32'(bus.Sys_RdEn && pop));
    cmp("slot_regaddr", 32'(raddr), 32'(bus.Sys_Address[3:0]));
    cmp("slot_wrdata", swd, bus.Sys_WrData);
    cmp("rd_valid", 32'(bus.Sys_RdValid), 32'(m_rv));
    cmp("rd_data", bus.Sys_RdData, m_rdata);
    cmp("int_req", 32'(req), 32'(m_req));
    if (m_req) cmp("int_id", 32'(id), 32'(m_id));
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(int s, int r, logic [31:0] d);
    bus.Sys_Address = 30'((s << 4) | r);
    bus.Sys_WrData = d;
    bus.Sys_WrEn = 1'b1;
    cyc();
    bus.Sys_WrEn = 1'b0;
  endtask
  task automatic rdchk(string nm_s, int s, int r, logic [31:0] exp);
    bus.Sys_Address = 30'((s << 4) | r);
    bus.Sys_RdEn = 1'b1;
    cyc();
    bus.Sys_RdEn = 1'b0;
    cmp({nm_s, "_valid"}, 32'(bus.Sys_RdValid), 32'h1);
    cmp(nm_s, bus.Sys_RdData, exp);
  endtask
  initial begin
    bus.Sys_Address = '0; bus.Sys_WrData = '0; bus.Sys_WrEn = 1'b0; bus.Sys_RdEn = 1'b0;
    srd = {8{32'h5A5A_0000}}; irq = '0; ack = 1'b0;
    cyc();
    live = 1'b1;
    cyc();
    rst = 1'b0;
    cmp("rst_req", 32'(req), 32'h0);
    cmp("rst_rdvalid", 32'(bus.Sys_RdValid), 32'h0);
    cmp("rst_rddata", bus.Sys_RdData, 32'h0);
    rdchk("mode_rst", 0, 2, 32'h0000_00FF);
    cmp("req_idle", 32'(req), 32'h0);
    bus.Sys_Address = 30'h35; bus.Sys_WrData = 32'hA5A5; bus.Sys_WrEn = 1'b1;
    #1;
    cmp("wr3_sel", 32'(sel), 32'h08);
    cmp("wr3_regaddr", 32'(raddr), 32'h5);
    cmp("wr3_wren", 32'(swe), 32'h1);
    cmp("wr3_wrdata", swd, 32'hA5A5);
    cyc();
    bus.Sys_WrEn = 1'b0;
    srd[64 +: 32] = 32'hDEAD_BEEF;
    srd[32 +: 32] = 32'h1234_5678;
    bus.Sys_Address = 30'h20; bus.Sys_RdEn = 1'b1;
    #1;
    cmp("rd2_sel", 32'(sel), 32'h0);
    cyc();
    bus.Sys_RdEn = 1'b0;
    cmp("rd2_data", bus.Sys_RdData, 32'h0);
    bus.Sys_Address = 30'h10_0017; bus.Sys_RdEn = 1'b1;
    cyc();
    bus.Sys_RdEn = 1'b0;
    cmp("rd1_alias", bus.Sys_RdData, 32'h1234_5678);
    wr(0, 1, 32'hC0);
    irq = 8'hC0;
    cyc(); cyc();
    cmp("prio_req", 32'(req), 32'h1);
    cmp("prio_id7", 32'(id), 32'h7);
    ack = 1'b1; cyc(); ack = 1'b0;
    cmp("ack_idle", 32'(req), 32'h0);
    irq = 8'h00;
    cyc();
    cmp("rearb_req", 32'(req), 32'h1);
    cmp("rearb_id6", 32'(id), 32'h6);
    rdchk("pend_40", 0, 0, 32'h40);
    irq = 8'h80;
    cyc(); cyc();
    cmp("nopreempt_id", 32'(id), 32'h6);
    cmp("nopreempt_req", 32'(req), 32'h1);
    wr(0, 0, 32'h40);
    cmp("withdraw_req", 32'(req), 32'h0);
    cyc();
    cmp("next_req", 32'(req), 32'h1);
    cmp("next_id7", 32'(id), 32'h7);
    ack = 1'b1; cyc(); ack = 1'b0;
    irq = 8'h00;
    wr(0, 2, 32'hFB);
    wr(0, 1, 32'h04);
    irq = 8'h04;
    cyc(); cyc();
    cmp("lvl_req", 32'(req), 32'h1);
    cmp("lvl_id2", 32'(id), 32'h2);
    ack = 1'b1; cyc(); ack = 1'b0;
    cmp("lvl_ack_idle", 32'(req), 32'h0);
    cyc();
    cmp("lvl_reassert", 32'(req), 32'h1);
    irq = 8'h00;
    cyc();
    cmp("lvl_withdraw", 32'(req), 32'h0);
    irq = 8'h04;
    cyc(); cyc();
    cmp("pre_rst_req", 32'(req), 32'h1);
    rdchk("pre_rst_mask", 0, 1, 32'h04);
    rst = 1'b1; irq = 8'h00;
    cyc();
    rst = 1'b0;
    cmp("midrst_req", 32'(req), 32'h0);
    cmp("midrst_id", 32'(id), 32'h0);
    cmp("midrst_rdvalid", 32'(bus.Sys_RdValid), 32'h0);
    cmp("midrst_rddata", bus.Sys_RdData, 32'h0);
    rdchk("post_pend", 0, 0, 32'h0);
    rdchk("post_mask", 0, 1, 32'h0);
    rdchk("post_mode", 0, 2, 32'hFF);
    for (int c = 0; c < 4000; c++) begin
      int s, r, k;
      logic [29:0] a;
      k = int'($urandom_range(0, 9));
      bus.Sys_WrEn = (k <= 2) || (k == 6);
      bus.Sys_RdEn = (k >= 3 && k <= 6);
      s = int'($urandom_range(0, 7));
      r = (s == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
      a = 30'($urandom);
      a[6:0] = 7'((s << 4) | r);
      bus.Sys_Address = a;
      bus.Sys_WrData = $urandom;
      srd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 2) == 0) irq = irq ^ 8'(1 << $urandom_range(0, 7));
      ack = req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0; bus.Sys_WrEn = 1'b0; bus.Sys_RdEn = 1'b0; ack = 1'b0;
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
